hook_trajectory_ctrl: RTL

HOOK_TRAJECTORY_CTRL -- requirements
Module: hook_trajectory_ctrl

---
 rtl/hook_trajectory_ctrl.sv | 228 ++++++++++++++++++++++
 1 files changed

// File: rtl/hook_trajectory_ctrl.sv
// Swinging hook controller: swing sweep, straight-line extend, weighted retract.
// Optional HOOK_AUTO_RETRACT_EN: extend auto-retracts after MAX_STEPS frames without a hit.
module hook_trajectory_ctrl #(
  parameter int ANGLE_STATES = 51,
  parameter int PIVOT_X      = 288,
  parameter int PIVOT_Y      = 64,
  parameter int SWING_DIV    = 4,
  parameter int MAX_WEIGHT   = 3,
  parameter int MAX_STEPS    = 60
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               startOfFrame,
  input  logic               launch,
  input  logic               collision,
  input  logic [1:0]         loadWeight,
  input  logic signed [10:0] tableOffX,
  input  logic signed [10:0] tableOffY,
  input  logic signed [10:0] tableSpdX,
  input  logic signed [10:0] tableSpdY,
  output logic [5:0]         angleIdx,
  output logic signed [10:0] topLeftX,
  output logic signed [10:0] topLeftY,
  output logic               isSwinging,
  output logic               retractDone,
  output logic [1:0]         grabbedWeight
);

  localparam logic [5:0]        AngLast   = 6'(ANGLE_STATES - 1);
  localparam logic [5:0]        DivLast   = 6'(SWING_DIV - 1);
  localparam logic [1:0]        WeightMax = (MAX_WEIGHT >= 3) ? 2'd3 : 2'(MAX_WEIGHT);
  localparam logic signed [10:0] PivX     = 11'(PIVOT_X);
  localparam logic signed [10:0] PivY     = 11'(PIVOT_Y);
  localparam logic [6:0]        StepSat   = 7'd127;
`ifdef HOOK_AUTO_RETRACT_EN
  localparam logic [6:0]        StepLim   = 7'(MAX_STEPS);
`endif

  // Elaboration-time parameter sanity.
  if (SWING_DIV < 1 || SWING_DIV > 63) begin : g_bad_div
    $error("SWING_DIV must be in 1..63");
  end
  if (ANGLE_STATES < 2 || ANGLE_STATES > 64) begin : g_bad_ang
    $error("ANGLE_STATES must be in 2..64");
  end
  if (MAX_STEPS < 1 || MAX_STEPS > 127) begin : g_bad_steps
    $error("MAX_STEPS must be in 1..127");
  end

  typedef enum logic [1:0] {ST_SWING, ST_EXTEND, ST_RETRACT} state_e;

  state_e             state_q, state_d;
  logic [5:0]         angle_q, angle_d;
  logic               dir_q, dir_d;          // 1 = moving right
  logic [5:0]         frame_q, frame_d;
  logic [6:0]         step_q, step_d;
  logic [2:0]         rcnt_q, rcnt_d;
  logic signed [10:0] spd_x_q, spd_x_d, spd_y_q, spd_y_d;
  logic signed [10:0] pos_x_q, pos_x_d, pos_y_q, pos_y_d;
  logic [1:0]         weight_q, weight_d;
  logic [1:0]         grab_q, grab_d;
  logic               hit_q, hit_d;
  logic               coll_prev_q, coll_prev_d;
  logic               done_q, done_d;
  logic               swing_q, swing_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_SWING;
      angle_q     <= '0;
      dir_q       <= 1'b1;
      frame_q     <= '0;
      step_q      <= '0;
      rcnt_q      <= '0;
      spd_x_q     <= '0;
      spd_y_q     <= '0;
      pos_x_q     <= PivX;
      pos_y_q     <= PivY;
      weight_q    <= '0;
      grab_q      <= '0;
      hit_q       <= 1'b0;
      coll_prev_q <= 1'b0;
      done_q      <= 1'b0;
      swing_q     <= 1'b1;
    end else begin
      state_q     <= state_d;
      angle_q     <= angle_d;
      dir_q       <= dir_d;
      frame_q     <= frame_d;
      step_q      <= step_d;
      rcnt_q      <= rcnt_d;
      spd_x_q     <= spd_x_d;
      spd_y_q     <= spd_y_d;
      pos_x_q     <= pos_x_d;
      pos_y_q     <= pos_y_d;
      weight_q    <= weight_d;
      grab_q      <= grab_d;
      hit_q       <= hit_d;
      coll_prev_q <= coll_prev_d;
      done_q      <= done_d;
      swing_q     <= swing_d;
    end
  end

  logic signed [10:0] swing_x, swing_y;
  logic [6:0]         step_inc;
  logic [2:0]         rcnt_last;
  logic               coll_edge;

  always_comb begin
    state_d     = state_q;
    angle_d     = angle_q;
    dir_d       = dir_q;
    frame_d     = frame_q;
    step_d      = step_q;
    rcnt_d      = rcnt_q;
    spd_x_d     = spd_x_q;
    spd_y_d     = spd_y_q;
    pos_x_d     = pos_x_q;
    pos_y_d     = pos_y_q;
    weight_d    = weight_q;
    grab_d      = grab_q;
    hit_d       = hit_q;
    coll_prev_d = collision;
    done_d      = 1'b0;

    swing_x   = PivX + tableOffX;
    swing_y   = PivY + tableOffY;
    step_inc  = (step_q == StepSat) ? step_q : step_q + 7'd1;
    coll_edge = collision & ~coll_prev_q;
    case (weight_q)
      2'd0:    rcnt_last = 3'd0;
      2'd1:    rcnt_last = 3'd1;
      2'd2:    rcnt_last = 3'd3;
      default: rcnt_last = 3'd7;
    endcase

    // First collision edge of a shot latches the load weight.
    if (state_q == ST_EXTEND && !hit_q && coll_edge) begin
      hit_d    = 1'b1;
      weight_d = (loadWeight > WeightMax) ? WeightMax : loadWeight;
    end

    if (startOfFrame) begin
      case (state_q)
        ST_SWING: begin
          pos_x_d = swing_x;
          pos_y_d = swing_y;
          if (launch) begin
            spd_x_d  = tableSpdX;
            spd_y_d  = tableSpdY;
            step_d   = '0;
            hit_d    = 1'b0;
            weight_d = '0;
            state_d  = ST_EXTEND;
          end else if (frame_q == DivLast) begin
            frame_d = '0;
            if (dir_q) begin
              if (angle_q == AngLast) begin
                angle_d = AngLast - 6'd1;
                dir_d   = 1'b0;
              end else begin
                angle_d = angle_q + 6'd1;
              end
            end else begin
              if (angle_q == 6'd0) begin
                angle_d = 6'd1;
                dir_d   = 1'b1;
              end else begin
                angle_d = angle_q - 6'd1;
              end
            end
          end else begin
            frame_d = frame_q + 6'd1;
          end
        end
        ST_EXTEND: begin
          if (hit_d) begin
            state_d = ST_RETRACT;
            rcnt_d  = '0;
          end else begin
            pos_x_d = pos_x_q + spd_x_q;
            pos_y_d = pos_y_q + spd_y_q;
            step_d  = step_inc;
`ifdef HOOK_AUTO_RETRACT_EN
            if (step_inc == StepLim) begin
              state_d  = ST_RETRACT;
              rcnt_d   = '0;
              weight_d = '0;
              hit_d    = 1'b1;
            end
`endif
          end
        end
        ST_RETRACT: begin
          // Final frame snaps back to the exact swing point for the frozen index.
          if (step_q == 7'd0 || (step_q == 7'd1 && rcnt_q == rcnt_last)) begin
            pos_x_d = swing_x;
            pos_y_d = swing_y;
            step_d  = '0;
            done_d  = 1'b1;
            grab_d  = weight_q;
            frame_d = '0;
            state_d = ST_SWING;
          end else if (rcnt_q == rcnt_last) begin
            pos_x_d = pos_x_q - spd_x_q;
            pos_y_d = pos_y_q - spd_y_q;
            step_d  = step_q - 7'd1;
            rcnt_d  = '0;
          end else begin
            rcnt_d = rcnt_q + 3'd1;
          end
        end
        default: state_d = ST_SWING;
      endcase
    end

    swing_d = (state_d == ST_SWING);
  end

  assign angleIdx      = angle_q;
  assign topLeftX      = pos_x_q;
  assign topLeftY      = pos_y_q;
  assign isSwinging    = swing_q;
  assign retractDone   = done_q;
  assign grabbedWeight = grab_q;

endmodule
